// File: rtl/srl32_arbiter.sv
// srl32_arbiter: two requesters share one logical-right-shift unit.
// Round-robin grant, req/done handshake, registered operands and result.
module srl32_arbiter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic             req1,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] res,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     opa;
  logic [SHAMT_W-1:0]   opb;
  logic                 gnt;
  logic                 last;
  logic                 pick;
  logic                 unused_b;

  // Requester 1 wins alone, or on a tie when 0 was granted last.
  always_comb begin
    pick = req1 & (~req0 | ~last);
  end

  assign unused_b = ^{B0[WIDTH-1:SHAMT_W], B1[WIDTH-1:SHAMT_W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      gnt   <= 1'b0;
      last  <= 1'b1;
      done0 <= 1'b0;
      done1 <= 1'b0;
      res   <= '0;
      busy  <= 1'b0;
      cnt0  <= '0;
      cnt1  <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req0 | req1) begin
            opa   <= pick ? A1 : A0;
            opb   <= pick ? B1[SHAMT_W-1:0]
                          : B0[SHAMT_W-1:0];
            gnt   <= pick;
            last  <= pick;
            busy  <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          res   <= opa >> opb;
          done0 <= ~gnt;
          done1 <= gnt;
          state <= DONE;
        end
        DONE: begin
          if (!gnt && cnt0 != '1)
            cnt0 <= cnt0 + 1'b1;
          if (gnt && cnt1 != '1)
            cnt1 <= cnt1 + 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
